// File: rtl/pp_loop_status_monitor.sv
// Purpose : passive activity monitor for one ap_ctrl_hs block containing one
//           pipelined loop; counts transactions, loop invocations, iteration
//           starts/ends, in-flight iterations, stall cycles and loop duration.
// Latency : every output is registered; an event in cycle t shows in cycle t+1.
// Backpressure: none; the monitor only observes and never drives the block.
// Ports:
//   clock, reset            : rising-edge clock, asynchronous active-high reset
//   finish                  : first assertion freezes all state, dump_valid pulses next cycle
//   ap_start/ready/done/continue : handshake of the monitored block
//   cur_state               : one-hot FSM state of the monitored block
//   pre_/post_loop_state0, *_valid : states bracketing the loop
//   iter_start_* / iter_end_* : loop state plus stage-0 / last-stage enable and block
//   loop_quit_state, quit_at_end : loop exit state and drain-before-exit flag
//   busy, loop_active, *_cnt, in_flight, max_in_flight, last_loop_cycles, dump_valid
module pp_loop_status_monitor #(
  parameter int STATE_W = 5,
  parameter int DEPTH   = 7,
  parameter int CNT_W   = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         finish,
  input  logic                         ap_start,
  input  logic                         ap_ready,
  input  logic                         ap_done,
  input  logic                         ap_continue,
  input  logic [STATE_W-1:0]           cur_state,
  input  logic [STATE_W-1:0]           pre_loop_state0,
  input  logic                         pre_states_valid,
  input  logic [STATE_W-1:0]           post_loop_state0,
  input  logic                         post_states_valid,
  input  logic [STATE_W-1:0]           iter_start_state,
  input  logic                         iter_start_enable,
  input  logic                         iter_start_block,
  input  logic [STATE_W-1:0]           iter_end_state,
  input  logic                         iter_end_enable,
  input  logic                         iter_end_block,
  input  logic [STATE_W-1:0]           loop_quit_state,
  input  logic                         quit_at_end,
  output logic                         busy,
  output logic                         loop_active,
  output logic [CNT_W-1:0]             txn_start_cnt,
  output logic [CNT_W-1:0]             txn_done_cnt,
  output logic [CNT_W-1:0]             loop_inv_cnt,
  output logic [CNT_W-1:0]             iter_start_cnt,
  output logic [CNT_W-1:0]             iter_end_cnt,
  output logic [$clog2(DEPTH+1)-1:0]   in_flight,
  output logic [$clog2(DEPTH+1)-1:0]   max_in_flight,
  output logic [CNT_W-1:0]             stall_cnt,
  output logic [CNT_W-1:0]             last_loop_cycles,
  output logic                         dump_valid
);

  localparam int             IFW     = $clog2(DEPTH + 1);
  localparam logic [IFW-1:0] DEPTH_V = IFW'(DEPTH);

  // Acceptance is defined by ap_start while idle, so ap_ready carries no
  // extra information for the counters.
  logic unused_ap_ready;
  assign unused_ap_ready = ap_ready;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [STATE_W-1:0] prev_state;
  logic [CNT_W-1:0]   loop_timer;
  logic               frozen;

  logic               txn_start, txn_done, busy_nxt;
  logic               start_ev, end_ev, loop_entry, loop_exit, stall_ev;
  logic [IFW-1:0]     in_flight_nxt;

  always_comb begin
    txn_done  = ap_done && ap_continue;
    // A completing transaction frees the block, so a start in the same cycle
    // is accepted back-to-back.
    txn_start = ap_start && (!busy || txn_done);
    busy_nxt  = busy;
    if (txn_start)     busy_nxt = 1'b1;
    else if (txn_done) busy_nxt = 1'b0;

    start_ev = (cur_state == iter_start_state) && iter_start_enable && !iter_start_block;
    end_ev   = (cur_state == iter_end_state) && iter_end_enable && !iter_end_block;

    // Saturation at either bound indicates a mismatch between the observed
    // enables and the declared depth; hold rather than wrap.
    in_flight_nxt = in_flight;
    if (start_ev && !end_ev) begin
      if (in_flight != DEPTH_V) in_flight_nxt = in_flight + IFW'(1);
    end else if (end_ev && !start_ev) begin
      if (in_flight != '0) in_flight_nxt = in_flight - IFW'(1);
    end

    loop_entry = start_ev && !loop_active &&
                 (!pre_states_valid || (prev_state == pre_loop_state0));

    loop_exit  = loop_active && (prev_state == loop_quit_state) &&
                 (post_states_valid ? (cur_state == post_loop_state0)
                                    : (cur_state != loop_quit_state)) &&
                 (!quit_at_end || (in_flight_nxt == '0));

    stall_ev   = loop_active && (cur_state == iter_start_state) && iter_start_block;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_state       <= '0;
      loop_timer       <= '0;
      frozen           <= 1'b0;
      busy             <= 1'b0;
      loop_active      <= 1'b0;
      txn_start_cnt    <= '0;
      txn_done_cnt     <= '0;
      loop_inv_cnt     <= '0;
      iter_start_cnt   <= '0;
      iter_end_cnt     <= '0;
      in_flight        <= '0;
      max_in_flight    <= '0;
      stall_cnt        <= '0;
      last_loop_cycles <= '0;
      dump_valid       <= 1'b0;
    end else begin
      dump_valid <= 1'b0;
      if (!frozen) begin
        if (finish) begin
          // Events of the finish cycle itself are not counted.
          frozen     <= 1'b1;
          dump_valid <= 1'b1;
        end else begin
          prev_state <= cur_state;
          busy       <= busy_nxt;
          if (txn_start) txn_start_cnt  <= sat_inc(txn_start_cnt);
          if (txn_done)  txn_done_cnt   <= sat_inc(txn_done_cnt);
          if (start_ev)  iter_start_cnt <= sat_inc(iter_start_cnt);
          if (end_ev)    iter_end_cnt   <= sat_inc(iter_end_cnt);
          if (stall_ev)  stall_cnt      <= sat_inc(stall_cnt);
          in_flight <= in_flight_nxt;
          if (in_flight_nxt > max_in_flight) max_in_flight <= in_flight_nxt;

          if (loop_entry) begin
            loop_active <= 1'b1;
            loop_timer  <= '0;
          end else if (loop_active) begin
            loop_timer <= sat_inc(loop_timer);
          end

          // The +1 accounts for the entry cycle, which precedes loop_active.
          if (loop_exit) begin
            loop_active      <= 1'b0;
            loop_inv_cnt     <= sat_inc(loop_inv_cnt);
            last_loop_cycles <= sat_inc(loop_timer);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pp_loop_status_monitor.sv
// Purpose : self-checking bench for pp_loop_status_monitor; expected values are
//           queued as stimulus is applied and popped when outputs are sampled.
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; the monitor is purely observational.
module tb_pp_loop_status_monitor;

  localparam int STATE_W = 5;
  localparam int DEPTH   = 7;
  localparam int CNT_W   = 32;
  localparam int IFW     = $clog2(DEPTH + 1);

  localparam logic [STATE_W-1:0] S_PRE  = 5'b00001;
  localparam logic [STATE_W-1:0] S_LOOP = 5'b00010;
  localparam logic [STATE_W-1:0] S_POST = 5'b00100;
  localparam logic [STATE_W-1:0] S_IDLE = 5'b10000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic finish, ap_start, ap_ready, ap_done, ap_continue;
  logic [STATE_W-1:0] cur_state, pre_loop_state0, post_loop_state0;
  logic [STATE_W-1:0] iter_start_state, iter_end_state, loop_quit_state;
  logic pre_states_valid, post_states_valid, quit_at_end;
  logic iter_start_enable, iter_start_block, iter_end_enable, iter_end_block;
  logic busy, loop_active, dump_valid;
  logic [CNT_W-1:0] txn_start_cnt, txn_done_cnt, loop_inv_cnt;
  logic [CNT_W-1:0] iter_start_cnt, iter_end_cnt, stall_cnt, last_loop_cycles;
  logic [IFW-1:0]   in_flight, max_in_flight;

  pp_loop_status_monitor #(.STATE_W(STATE_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .finish(finish),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .cur_state(cur_state),
    .pre_loop_state0(pre_loop_state0), .pre_states_valid(pre_states_valid),
    .post_loop_state0(post_loop_state0), .post_states_valid(post_states_valid),
    .iter_start_state(iter_start_state), .iter_start_enable(iter_start_enable),
    .iter_start_block(iter_start_block),
    .iter_end_state(iter_end_state), .iter_end_enable(iter_end_enable),
    .iter_end_block(iter_end_block),
    .loop_quit_state(loop_quit_state), .quit_at_end(quit_at_end),
    .busy(busy), .loop_active(loop_active),
    .txn_start_cnt(txn_start_cnt), .txn_done_cnt(txn_done_cnt),
    .loop_inv_cnt(loop_inv_cnt), .iter_start_cnt(iter_start_cnt),
    .iter_end_cnt(iter_end_cnt), .in_flight(in_flight), .max_in_flight(max_in_flight),
    .stall_cnt(stall_cnt), .last_loop_cycles(last_loop_cycles), .dump_valid(dump_valid)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;
  logic [CNT_W-1:0] exp_q[$];
  logic [CNT_W-1:0] e;
  logic [CNT_W-1:0] all_outs;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    finish = 0; ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 0;
    cur_state = S_IDLE;
    iter_start_enable = 0; iter_start_block = 0;
    iter_end_enable = 0; iter_end_block = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
    tick();
  endtask

  // OR of every output bit; zero only when all outputs are zero.
  task automatic fold_outputs();
    all_outs = txn_start_cnt | txn_done_cnt | loop_inv_cnt | iter_start_cnt |
               iter_end_cnt | stall_cnt | last_loop_cycles |
               CNT_W'(in_flight) | CNT_W'(max_in_flight) |
               CNT_W'({busy, loop_active, dump_valid});
  endtask

  // One loop invocation: PRE cycle, n issues at II=1, each iteration retiring
  // 7 issue-slots later, optional stall of stall_len cycles before slot stall_k,
  // then the POST state and one idle cycle.
  task automatic run_loop(input int n, input int stall_k, input int stall_len);
    cur_state = S_PRE;
    tick();
    for (int k = 0; k < n + 7; k++) begin
      if (k == stall_k) begin
        for (int j = 0; j < stall_len; j++) begin
          cur_state = S_LOOP;
          iter_start_enable = 1; iter_start_block = 1;
          iter_end_enable = 1;   iter_end_block = 1;
          tick();
        end
      end
      cur_state = S_LOOP;
      iter_start_enable = (k < n);  iter_start_block = 0;
      iter_end_enable   = (k >= 7); iter_end_block   = 0;
      tick();
    end
    cur_state = S_POST;
    iter_start_enable = 0; iter_end_enable = 0;
    iter_start_block = 0;  iter_end_block = 0;
    tick();
    cur_state = S_IDLE;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    exp_q.push_back(0);
    tick();
    tick();
    fold_outputs();
    e = exp_q.pop_front(); vectors++;
    if (all_outs !== e) begin miscompares++; $display("FAIL reset_held: outputs or %0h, want %0h", all_outs, e); end
    reset = 0;
    exp_q.push_back(0);
    tick();
    tick();
    fold_outputs();
    e = exp_q.pop_front(); vectors++;
    if (all_outs !== e) begin miscompares++; $display("FAIL reset_released: outputs or %0h, want %0h", all_outs, e); end
  endtask

  task automatic test_transaction();
    do_reset();
    ap_start = 1;
    exp_q.push_back(1);
    tick(); tick(); tick();
    ap_start = 0;
    for (int i = 0; i < 17; i++) tick();
    e = exp_q.pop_front(); vectors++;
    if (busy !== e[0]) begin miscompares++; $display("FAIL txn_busy_mid: got %0d, want %0d", busy, e[0]); end
    ap_done = 1; ap_continue = 1;
    exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(0);
    tick();
    ap_done = 0; ap_continue = 0;
    e = exp_q.pop_front(); vectors++;
    if (txn_start_cnt !== e) begin miscompares++; $display("FAIL txn_start_cnt: got %0d, want %0d", txn_start_cnt, e); end
    e = exp_q.pop_front(); vectors++;
    if (txn_done_cnt !== e) begin miscompares++; $display("FAIL txn_done_cnt: got %0d, want %0d", txn_done_cnt, e); end
    e = exp_q.pop_front(); vectors++;
    if (busy !== e[0]) begin miscompares++; $display("FAIL txn_busy_after: got %0d, want %0d", busy, e[0]); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ap_start = 1; tick();
    ap_start = 0; tick(); tick(); tick();
    ap_start = 1; ap_done = 1; ap_continue = 1;
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(1);
    tick();
    ap_done = 0; ap_continue = 0;
    e = exp_q.pop_front(); vectors++;
    if (busy !== e[0]) begin miscompares++; $display("FAIL b2b_busy: got %0d, want %0d", busy, e[0]); end
    e = exp_q.pop_front(); vectors++;
    if (txn_start_cnt !== e) begin miscompares++; $display("FAIL b2b_start_cnt: got %0d, want %0d", txn_start_cnt, e); end
    e = exp_q.pop_front(); vectors++;
    if (txn_done_cnt !== e) begin miscompares++; $display("FAIL b2b_done_cnt: got %0d, want %0d", txn_done_cnt, e); end
    // ap_start still high while busy: ignored.
    exp_q.push_back(2);
    tick();
    ap_start = 0;
    e = exp_q.pop_front(); vectors++;
    if (txn_start_cnt !== e) begin miscompares++; $display("FAIL busy_start_ignored: got %0d, want %0d", txn_start_cnt, e); end
  endtask

  task automatic test_loop(input bit with_stall);
    do_reset();
    post_states_valid = !with_stall;
    if (with_stall) begin
      // Loop state spans 17 issue slots plus 4 stall cycles.
      exp_q.push_back(10); exp_q.push_back(10); exp_q.push_back(7);
      exp_q.push_back(21); exp_q.push_back(1);  exp_q.push_back(4);
      exp_q.push_back(0);  exp_q.push_back(0);
      run_loop(10, 5, 4);
    end else begin
      // Entry in slot 0; loop state held 17 cycles (10 issues + 7 to drain).
      exp_q.push_back(10); exp_q.push_back(10); exp_q.push_back(7);
      exp_q.push_back(17); exp_q.push_back(1);  exp_q.push_back(0);
      exp_q.push_back(0);  exp_q.push_back(0);
      run_loop(10, -1, 0);
    end
    e = exp_q.pop_front(); vectors++;
    if (iter_start_cnt !== e) begin miscompares++; $display("FAIL loop_iter_start stall=%0d: got %0d, want %0d", with_stall, iter_start_cnt, e); end
    e = exp_q.pop_front(); vectors++;
    if (iter_end_cnt !== e) begin miscompares++; $display("FAIL loop_iter_end stall=%0d: got %0d, want %0d", with_stall, iter_end_cnt, e); end
    e = exp_q.pop_front(); vectors++;
    if (max_in_flight !== e[IFW-1:0]) begin miscompares++; $display("FAIL loop_max_in_flight stall=%0d: got %0d, want %0d", with_stall, max_in_flight, e); end
    e = exp_q.pop_front(); vectors++;
    if (last_loop_cycles !== e) begin miscompares++; $display("FAIL loop_cycles stall=%0d: got %0d, want %0d", with_stall, last_loop_cycles, e); end
    e = exp_q.pop_front(); vectors++;
    if (loop_inv_cnt !== e) begin miscompares++; $display("FAIL loop_inv_cnt stall=%0d: got %0d, want %0d", with_stall, loop_inv_cnt, e); end
    e = exp_q.pop_front(); vectors++;
    if (stall_cnt !== e) begin miscompares++; $display("FAIL loop_stall_cnt stall=%0d: got %0d, want %0d", with_stall, stall_cnt, e); end
    e = exp_q.pop_front(); vectors++;
    if (in_flight !== e[IFW-1:0]) begin miscompares++; $display("FAIL loop_in_flight_end stall=%0d: got %0d, want %0d", with_stall, in_flight, e); end
    e = exp_q.pop_front(); vectors++;
    if (loop_active !== e[0]) begin miscompares++; $display("FAIL loop_active_end stall=%0d: got %0d, want %0d", with_stall, loop_active, e[0]); end
    post_states_valid = 1;
  endtask

  task automatic test_finish();
    do_reset();
    cur_state = S_PRE;
    tick();
    cur_state = S_LOOP; iter_start_enable = 1;
    tick(); tick(); tick();
    exp_q.push_back(3); exp_q.push_back(1); exp_q.push_back(0);
    exp_q.push_back(3); exp_q.push_back(1);
    exp_q.push_back(0); exp_q.push_back(3); exp_q.push_back(0); exp_q.push_back(1);
    e = exp_q.pop_front(); vectors++;
    if (iter_start_cnt !== e) begin miscompares++; $display("FAIL fin_pre_count: got %0d, want %0d", iter_start_cnt, e); end
    finish = 1;
    tick();
    finish = 0;
    e = exp_q.pop_front(); vectors++;
    if (dump_valid !== e[0]) begin miscompares++; $display("FAIL fin_dump_pulse: got %0d, want %0d", dump_valid, e[0]); end
    tick();
    e = exp_q.pop_front(); vectors++;
    if (dump_valid !== e[0]) begin miscompares++; $display("FAIL fin_dump_once: got %0d, want %0d", dump_valid, e[0]); end
    e = exp_q.pop_front(); vectors++;
    if (iter_start_cnt !== e) begin miscompares++; $display("FAIL fin_frozen_count: got %0d, want %0d", iter_start_cnt, e); end
    e = exp_q.pop_front(); vectors++;
    if (loop_active !== e[0]) begin miscompares++; $display("FAIL fin_frozen_active: got %0d, want %0d", loop_active, e[0]); end
    finish = 1;
    tick();
    finish = 0;
    tick();
    e = exp_q.pop_front(); vectors++;
    if (dump_valid !== e[0]) begin miscompares++; $display("FAIL fin_second_ignored: got %0d, want %0d", dump_valid, e[0]); end
    e = exp_q.pop_front(); vectors++;
    if (in_flight !== e[IFW-1:0]) begin miscompares++; $display("FAIL fin_frozen_in_flight: got %0d, want %0d", in_flight, e); end
    e = exp_q.pop_front(); vectors++;
    if (txn_start_cnt !== e) begin miscompares++; $display("FAIL fin_frozen_txn: got %0d, want %0d", txn_start_cnt, e); end
    e = exp_q.pop_front(); vectors++;
    if (busy !== !e[0]) begin miscompares++; $display("FAIL fin_frozen_busy: got %0d, want %0d", busy, !e[0]); end
    iter_start_enable = 0;
  endtask

  task automatic test_async_reset();
    do_reset();
    ap_start = 1;
    cur_state = S_PRE;
    tick();
    ap_start = 0;
    cur_state = S_LOOP; iter_start_enable = 1;
    tick(); tick(); tick();
    exp_q.push_back(1); exp_q.push_back(0);
    e = exp_q.pop_front(); vectors++;
    if (loop_active !== e[0]) begin miscompares++; $display("FAIL arst_loop_running: got %0d, want %0d", loop_active, e[0]); end
    #3;
    reset = 1;
    #1;
    fold_outputs();
    e = exp_q.pop_front(); vectors++;
    if (all_outs !== e) begin miscompares++; $display("FAIL arst_immediate: outputs or %0h, want %0h", all_outs, e); end
    idle_inputs();
    tick();
    reset = 0;
    tick();
    exp_q.push_back(1); exp_q.push_back(10);
    run_loop(10, -1, 0);
    e = exp_q.pop_front(); vectors++;
    if (loop_inv_cnt !== e) begin miscompares++; $display("FAIL arst_no_partial: got %0d, want %0d", loop_inv_cnt, e); end
    e = exp_q.pop_front(); vectors++;
    if (iter_start_cnt !== e) begin miscompares++; $display("FAIL arst_fresh_count: got %0d, want %0d", iter_start_cnt, e); end
  endtask

  task automatic test_boundaries();
    do_reset();
    cur_state = S_LOOP;
    iter_end_enable = 1;
    exp_q.push_back(0); exp_q.push_back(1);
    tick();
    iter_end_enable = 0;
    e = exp_q.pop_front(); vectors++;
    if (in_flight !== e[IFW-1:0]) begin miscompares++; $display("FAIL sat_low_in_flight: got %0d, want %0d", in_flight, e); end
    e = exp_q.pop_front(); vectors++;
    if (iter_end_cnt !== e) begin miscompares++; $display("FAIL sat_low_end_cnt: got %0d, want %0d", iter_end_cnt, e); end
    // Nine issues with no retirements; previous state is never PRE so the
    // loop is never entered.
    iter_start_enable = 1;
    exp_q.push_back(7); exp_q.push_back(7); exp_q.push_back(9); exp_q.push_back(0);
    for (int i = 0; i < 9; i++) tick();
    iter_start_block = 1;
    exp_q.push_back(0);
    tick();
    iter_start_enable = 0; iter_start_block = 0;
    e = exp_q.pop_front(); vectors++;
    if (in_flight !== e[IFW-1:0]) begin miscompares++; $display("FAIL sat_high_in_flight: got %0d, want %0d", in_flight, e); end
    e = exp_q.pop_front(); vectors++;
    if (max_in_flight !== e[IFW-1:0]) begin miscompares++; $display("FAIL sat_high_max: got %0d, want %0d", max_in_flight, e); end
    e = exp_q.pop_front(); vectors++;
    if (iter_start_cnt !== e) begin miscompares++; $display("FAIL deferred_start_cnt: got %0d, want %0d", iter_start_cnt, e); end
    e = exp_q.pop_front(); vectors++;
    if (loop_active !== e[0]) begin miscompares++; $display("FAIL deferred_entry: got %0d, want %0d", loop_active, e[0]); end
    e = exp_q.pop_front(); vectors++;
    if (stall_cnt !== e) begin miscompares++; $display("FAIL stall_inactive: got %0d, want %0d", stall_cnt, e); end
  endtask

  initial begin
    pre_loop_state0   = S_PRE;  pre_states_valid  = 1;
    post_loop_state0  = S_POST; post_states_valid = 1;
    iter_start_state  = S_LOOP; iter_end_state    = S_LOOP;
    loop_quit_state   = S_LOOP; quit_at_end       = 1;
    idle_inputs();
    test_reset();
    test_transaction();
    test_back_to_back();
    test_loop(1'b0);
    test_loop(1'b1);
    test_finish();
    test_async_reset();
    test_boundaries();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
